// File: rtl/sensor_debounce.sv
// sensor_debounce: six independent vehicle-loop sensor debouncers.
// Each raw bit passes through a 2-flop synchronizer and a per-channel FSM
// (LOW, RISE_CHK, HIGH, FALL_CHK[, STUCK]) that produces a clean level,
// a one-cycle rise pulse, and (optionally) a sticky stuck-high fault flag.
// Build option: define SENSOR_STUCK_EN to include the stuck counter, the
// STUCK state and the fault logic; otherwise fault is tied low.
module sensor_debounce #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] raw,
    input  logic       fault_clr,
    output logic [5:0] d_clean,
    output logic [5:0] rise,
    output logic [5:0] fault
);

    localparam int unsigned NCH       = 6;
    localparam logic [7:0]  DEB_LIM   = 8'(DEB_CYCLES);
    localparam logic [15:0] STUCK_LIM = 16'(STUCK_CYCLES);

`ifdef SENSOR_STUCK_EN
    typedef enum logic [2:0] {
        ST_LOW, ST_RISE_CHK, ST_HIGH, ST_FALL_CHK, ST_STUCK
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_LOW, ST_RISE_CHK, ST_HIGH, ST_FALL_CHK
    } state_e;
`endif

    logic [5:0] sync1_q;
    logic [5:0] sync2_q;
    state_e     state_q [NCH];
    state_e     state_d [NCH];
    logic [7:0] deb_q   [NCH];
    logic [7:0] deb_d   [NCH];
    logic [5:0] clean_q, clean_d;
    logic [5:0] rise_q,  rise_d;
`ifdef SENSOR_STUCK_EN
    logic [15:0] stk_q [NCH];
    logic [15:0] stk_d [NCH];
    logic [15:0] stk_nx;
    logic [5:0]  fault_q, fault_d;
`endif

    function automatic logic [7:0] inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Per-channel next-state, counter and output computation.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        clean_d = clean_q;
        rise_d  = '0;
`ifdef SENSOR_STUCK_EN
        stk_d   = stk_q;
        stk_nx  = '0;
        fault_d = fault_q;
`endif
        for (int unsigned n = 0; n < NCH; n++) begin
            unique case (state_q[n])
                ST_LOW: begin
                    clean_d[n] = 1'b0;
                    if (sync2_q[n]) begin
                        state_d[n] = ST_RISE_CHK;
                        deb_d[n]   = 8'd1;
                    end else begin
                        deb_d[n]   = '0;
                    end
                end
                ST_RISE_CHK: begin
                    if (!sync2_q[n]) begin
                        state_d[n] = ST_LOW;
                        deb_d[n]   = '0;
                    end else if (deb_q[n] == DEB_LIM) begin
                        state_d[n] = ST_HIGH;
                        deb_d[n]   = '0;
                        clean_d[n] = 1'b1;
                        rise_d[n]  = 1'b1;
`ifdef SENSOR_STUCK_EN
                        stk_d[n]   = '0;
`endif
                    end else begin
                        deb_d[n]   = inc8(deb_q[n]);
                    end
                end
                ST_HIGH: begin
`ifdef SENSOR_STUCK_EN
                    stk_nx   = inc16(stk_q[n]);
                    stk_d[n] = stk_nx;
                    if (stk_nx == STUCK_LIM) begin
                        state_d[n] = ST_STUCK;
                        deb_d[n]   = '0;
                        clean_d[n] = 1'b0;
                    end else
`endif
                    if (!sync2_q[n]) begin
                        state_d[n] = ST_FALL_CHK;
                        deb_d[n]   = 8'd1;
                    end
                end
                ST_FALL_CHK: begin
`ifdef SENSOR_STUCK_EN
                    stk_nx   = inc16(stk_q[n]);
                    stk_d[n] = stk_nx;
                    if (stk_nx == STUCK_LIM) begin
                        state_d[n] = ST_STUCK;
                        deb_d[n]   = '0;
                        clean_d[n] = 1'b0;
                    end else
`endif
                    if (sync2_q[n]) begin
                        // Bounce back: level never dropped, so no rise pulse.
                        state_d[n] = ST_HIGH;
                        deb_d[n]   = '0;
                    end else if (deb_q[n] == DEB_LIM) begin
                        state_d[n] = ST_LOW;
                        deb_d[n]   = '0;
                        clean_d[n] = 1'b0;
                    end else begin
                        deb_d[n]   = inc8(deb_q[n]);
                    end
                end
`ifdef SENSOR_STUCK_EN
                ST_STUCK: begin
                    clean_d[n] = 1'b0;
                    if (sync2_q[n]) begin
                        deb_d[n]   = '0;
                    end else if (inc8(deb_q[n]) == DEB_LIM) begin
                        state_d[n] = ST_LOW;
                        deb_d[n]   = '0;
                    end else begin
                        deb_d[n]   = inc8(deb_q[n]);
                    end
                end
`endif
                default: begin
                    state_d[n] = ST_LOW;
                    deb_d[n]   = '0;
                    clean_d[n] = 1'b0;
                end
            endcase
`ifdef SENSOR_STUCK_EN
            // Set wins over clear; clear is ignored while the channel is stuck.
            fault_d[n] = (state_d[n] == ST_STUCK) |
                         (fault_q[n] & ~(fault_clr & (state_q[n] != ST_STUCK)));
`endif
        end
    end

    // Synchronizers, channel state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            for (int unsigned n = 0; n < NCH; n++) begin
                state_q[n] <= ST_LOW;
                deb_q[n]   <= '0;
`ifdef SENSOR_STUCK_EN
                stk_q[n]   <= '0;
`endif
            end
`ifdef SENSOR_STUCK_EN
            fault_q <= '0;
`endif
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            state_q <= state_d;
            deb_q   <= deb_d;
`ifdef SENSOR_STUCK_EN
            stk_q   <= stk_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign d_clean = clean_q;
    assign rise    = rise_q;

`ifdef SENSOR_STUCK_EN
    assign fault = fault_q;
`else
    logic unused_stuck;
    assign unused_stuck = &{1'b0, fault_clr, STUCK_LIM};
    assign fault = '0;
`endif

endmodule

// File: tb/tb_sensor_debounce.sv
// Self-checking bench for sensor_debounce (DEB_CYCLES=4, STUCK_CYCLES=20).
// Directed table, hand-written stuck/reset sequences, then random stimulus
// against a run-length reference model. Honors SENSOR_STUCK_EN.
module tb_sensor_debounce;

    localparam int DEB = 4;
    localparam int STK = 20;
`ifdef SENSOR_STUCK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [5:0] raw;
    logic       fault_clr;
    logic [5:0] d_clean;
    logic [5:0] rise;
    logic [5:0] fault;

    int tests;
    int failed;

    sensor_debounce #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STK)) dut (
        .clk      (clk),
        .reset    (reset),
        .raw      (raw),
        .fault_clr(fault_clr),
        .d_clean  (d_clean),
        .rise     (rise),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sync delay as a raw history queue, debounce as a
    // run length of samples disagreeing with the clean level.
    logic [5:0] rawq[$];
    bit [5:0]   m_clean, m_rise, m_fault, m_stuck;
    int         m_run[6], m_age[6], m_lowrun[6];

    task automatic model_reset();
        rawq.delete();
        m_clean = '0; m_rise = '0; m_fault = '0; m_stuck = '0;
        for (int n = 0; n < 6; n++) begin
            m_run[n] = 0; m_age[n] = 0; m_lowrun[n] = 0;
        end
    endtask

    task automatic model_step();
        logic [5:0] sv;
        rawq.push_back(raw);
        if (rawq.size() > 3) void'(rawq.pop_front());
        sv = (rawq.size() == 3) ? rawq[0] : 6'd0;
        for (int n = 0; n < 6; n++) begin
            bit s;
            bit was_stuck;
            s = sv[n];
            was_stuck = m_stuck[n];
            m_rise[n] = 1'b0;
            if (m_stuck[n]) begin
                if (s) m_lowrun[n] = 0;
                else begin
                    m_lowrun[n]++;
                    if (m_lowrun[n] == DEB) begin
                        m_stuck[n] = 1'b0; m_lowrun[n] = 0; m_run[n] = 0;
                    end
                end
            end else begin
                if (m_clean[n]) m_age[n]++;
                if (STK_EN && m_clean[n] && m_age[n] >= STK) begin
                    m_stuck[n] = 1'b1; m_clean[n] = 1'b0;
                    m_run[n] = 0; m_lowrun[n] = 0;
                end else if (s != m_clean[n]) begin
                    m_run[n]++;
                    if (m_run[n] == DEB + 1) begin
                        m_clean[n] = s; m_run[n] = 0;
                        if (s) begin m_rise[n] = 1'b1; m_age[n] = 0; end
                    end
                end else begin
                    m_run[n] = 0;
                end
            end
            if (m_stuck[n]) m_fault[n] = 1'b1;
            else if (fault_clr && !was_stuck) m_fault[n] = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic [5:0] ed, input logic [5:0] er,
                        input logic [5:0] ef);
        chk({nm, " d_clean"}, d_clean, ed);
        chk({nm, " rise"},    rise,    er);
        chk({nm, " fault"},   fault,   ef);
    endtask

    // One clock: drive at negedge, edge, model update, return at next negedge.
    task automatic cycle(input logic [5:0] r, input logic fc);
        raw = r;
        fault_clr = fc;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [5:0] r;
        logic       fc;
        logic [5:0] ed;
        logic [5:0] er;
        logic [5:0] ef;
    } vec_t;

    vec_t vec[23];

    int         hold[6];
    logic [5:0] rr;

    initial begin
        tests = 0;
        failed = 0;
        raw = '0;
        fault_clr = 1'b0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk3("reset state", 6'h00, 6'h00, 6'h00);
        reset = 1'b0;

        // Entry i: inputs applied for edge i, outputs expected after edge i.
        for (int i = 0; i < 23; i++) begin
            if (i <= 7)       vec[i].r = 6'b000001;
            else if (i <= 10) vec[i].r = 6'b000101;
            else if (i <= 13) vec[i].r = 6'b000001;
            else if (i <= 15) vec[i].r = 6'b000000;
            else              vec[i].r = 6'b000001;
            vec[i].fc = 1'b0;
            vec[i].ed = (i >= 6) ? 6'b000001 : 6'b000000;
            vec[i].er = (i == 6) ? 6'b000001 : 6'b000000;
            vec[i].ef = 6'b000000;
        end
        for (int i = 0; i < 23; i++) begin
            cycle(vec[i].r, vec[i].fc);
            chk3($sformatf("table edge %0d", i), vec[i].ed, vec[i].er, vec[i].ef);
        end

        // Stuck-high channel 4, fault_clr ignored while stuck, then recovery.
        do_reset();
        for (int e = 0; e <= 54; e++) begin
            rr = (e <= 40 || e >= 48) ? 6'b010000 : 6'b000000;
            cycle(rr, (e == 28 || e == 47));
            case (e)
                25: chk3("stuck e25", 6'b010000, 6'h00, 6'h00);
                26: chk3("stuck e26", STK_EN ? 6'h00 : 6'b010000, 6'h00,
                         STK_EN ? 6'b010000 : 6'h00);
                28: chk("stuck clr-ignored e28", fault, STK_EN ? 6'b010000 : 6'h00);
                40: chk3("stuck e40", STK_EN ? 6'h00 : 6'b010000, 6'h00,
                         STK_EN ? 6'b010000 : 6'h00);
                46: chk3("stuck e46", STK_EN ? 6'h00 : 6'b010000, 6'h00,
                         STK_EN ? 6'b010000 : 6'h00);
                47: chk3("stuck e47 cleared", 6'h00, 6'h00, 6'h00);
                54: chk3("re-rise e54", 6'b010000, 6'b010000, 6'h00);
                default: ;
            endcase
        end

        // Asynchronous reset between clock edges clears outputs at once.
        #1 reset = 1'b1;
        #1 chk3("async reset", 6'h00, 6'h00, 6'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Reset mid-RISE_CHK with all channels high, then full re-debounce.
        for (int e = 0; e <= 3; e++) cycle(6'h3F, 1'b0);
        chk3("mid rise_chk", 6'h00, 6'h00, 6'h00);
        do_reset();
        for (int e = 0; e <= 7; e++) begin
            cycle(6'h3F, 1'b0);
            chk3($sformatf("post-reset edge %0d", e), (e >= 6) ? 6'h3F : 6'h00,
                 (e == 6) ? 6'h3F : 6'h00, 6'h00);
        end

        // Random stimulus versus the reference model.
        do_reset();
        rr = '0;
        for (int n = 0; n < 6; n++) hold[n] = $urandom_range(1, 8);
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < 6; n++) begin
                hold[n]--;
                if (hold[n] <= 0) begin
                    rr[n] = ~rr[n];
                    hold[n] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 35)
                                                          : $urandom_range(1, 9);
                end
            end
            cycle(rr, ($urandom_range(0, 11) == 0));
            chk3($sformatf("random c%0d", c), m_clean, m_rise, m_fault);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
